// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave receiver and its synchroniser.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int              SPI_DW         = 8;
  localparam logic [SPI_DW-1:0] SPI_DEFAULT_TX = 8'h00;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage flop chain bringing asynchronous SPI pins into the clk domain.
module spi_sync
  import spi_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Reset to the bus idle levels so no false edge is seen on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave, MSB first, oversampled in the clk domain.
// Build option SPI_SLAVE_MISO_TRISTATE_EN releases miso to z while deselected.
//
// state | meaning
// IDLE  | deselected; miso at idle value; waiting for ss_n to fall
// SHIFT | selected; mosi shifted in on sck rise, miso shifted out on sck fall
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int            DW          = SPI_DW,
  parameter logic [DW-1:0] DEFAULT_TX  = DW'(SPI_DEFAULT_TX),
  parameter int            SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sck,
  input  logic          ss_n,
  input  logic          mosi,
  output logic          miso,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          busy
);

  localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  logic [2:0] pins_s;
  logic       sck_d, sck_dd, ss_d, ss_dd, mosi_d;
  logic       sck_rise, sck_fall, ss_fall, ss_rise;

  spi_state_e    state, state_nxt;
  logic [CW-1:0] bit_cnt, cnt_nxt;
  logic [DW-1:0] rx_shift, rx_nxt, tx_shift, tx_nxt, rx_data_nxt;
  logic [DW-1:0] load_word, rx_word;
  logic          reload, reload_nxt, miso_q, miso_nxt, tx_ready_nxt, rx_valid_nxt;

  spi_sync #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES),
    .RST_VAL(3'b010)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({mosi, ss_n, sck}),
    .q    (pins_s)
  );

  // One extra stage so mosi stays aligned with the sck edge strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_d  <= 1'b0;
      sck_dd <= 1'b0;
      ss_d   <= 1'b1;
      ss_dd  <= 1'b1;
      mosi_d <= 1'b0;
    end else begin
      sck_d  <= pins_s[0];
      sck_dd <= sck_d;
      ss_d   <= pins_s[1];
      ss_dd  <= ss_d;
      mosi_d <= pins_s[2];
    end
  end

  assign sck_rise  = sck_d & ~sck_dd;
  assign sck_fall  = ~sck_d & sck_dd;
  assign ss_fall   = ~ss_d & ss_dd;
  assign ss_rise   = ss_d & ~ss_dd;
  assign load_word = tx_valid ? tx_data : DEFAULT_TX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      reload   <= 1'b0;
      miso_q   <= 1'b0;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= cnt_nxt;
      rx_shift <= rx_nxt;
      tx_shift <= tx_nxt;
      reload   <= reload_nxt;
      miso_q   <= miso_nxt;
      tx_ready <= tx_ready_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = bit_cnt;
    rx_nxt       = rx_shift;
    tx_nxt       = tx_shift;
    reload_nxt   = reload;
    miso_nxt     = miso_q;
    tx_ready_nxt = 1'b0;
    rx_valid_nxt = 1'b0;
    rx_data_nxt  = rx_data;
    rx_word      = {rx_shift[DW-2:0], mosi_d};
    case (state)
      IDLE: begin
        miso_nxt = 1'b0;
        if (ss_fall) begin
          tx_nxt       = load_word;
          tx_ready_nxt = 1'b1;
          miso_nxt     = load_word[DW-1];
          cnt_nxt      = '0;
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        // Deselect beats a coincident sck edge; the partial word is dropped.
        if (ss_rise) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          rx_nxt     = '0;
          reload_nxt = 1'b0;
          miso_nxt   = 1'b0;
        end else if (sck_rise) begin
          rx_nxt = rx_word;
          if (bit_cnt == CNT_LAST) begin
            rx_data_nxt  = rx_word;
            rx_valid_nxt = 1'b1;
            cnt_nxt      = '0;
            reload_nxt   = 1'b1;
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end else if (sck_fall) begin
          if (reload) begin
            tx_nxt       = load_word;
            tx_ready_nxt = 1'b1;
            reload_nxt   = 1'b0;
          end else begin
            tx_nxt = {tx_shift[DW-2:0], 1'b0};
          end
          miso_nxt = tx_nxt[DW-1];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = (state == SHIFT) ? miso_q : 1'bz;
`else
  assign miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed cases plus randomized frames.
`timescale 1ns/1ps
module tb_spi_slave_rx;

  localparam logic [7:0] DFLT = 8'h00;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  wire        miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, busy;

  int checks = 0, errors = 0;

  // TX words offered to the DUT; tx_pop advances on each accepted load.
  logic [7:0] tx_mem [256];
  int         tx_push = 0, tx_pop = 0;
  // Received words captured from rx_valid pulses.
  logic [7:0] rx_mem [256];
  int         rx_wr = 0, rx_rd = 0, n_ready = 0;

  // Reference model state.
  logic [7:0] mo_bytes [4];
  logic [7:0] model_q [$];
  logic [7:0] rx_exp [$];
  logic [7:0] last_rx = 8'h00;
  int         rx_total = 0, ready_exp = 0;

  assign tx_valid = (tx_pop < tx_push);
  assign tx_data  = tx_mem[tx_pop[7:0]];

  spi_slave_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sck     (sck),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .miso    (miso),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_mem[rx_wr[7:0]] = rx_data;
      rx_wr++;
    end
    if (tx_ready) begin
      n_ready++;
      if (tx_valid) tx_pop++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] w);
    tx_mem[tx_push[7:0]] = w;
    tx_push++;
    model_q.push_back(w);
  endtask

  // Mode-0 master: mosi changes on sck fall, miso sampled one clk after each fall.
  // The final sck fall coincides with ss_n rising.
  task automatic frame(input int nbits, input int h);
    logic [7:0] mi, exp_w;
    mi = '0;
    exp_w = '0;
    ss_n = 1'b0;
    mosi = mo_bytes[0][7];
    repeat (h) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      int byi;
      int bi;
      byi = b / 8;
      bi  = 7 - (b % 8);
      if (bi == 7) begin
        exp_w = (model_q.size() > 0) ? model_q.pop_front() : DFLT;
        ready_exp++;
      end
      sck = 1'b1;
      repeat (h) @(negedge clk);
      if (b == 0) chk("busy_sel", 32'(busy), 32'(1'b1));
      sck = 1'b0;
      if (b == nbits - 1) ss_n = 1'b1;
      else mosi = mo_bytes[(b + 1) / 8][7 - ((b + 1) % 8)];
      @(negedge clk);
      mi[bi] = miso;
      if (bi == 0) begin
        chk("miso_word", 32'(mi), 32'(exp_w));
        rx_exp.push_back(mo_bytes[byi]);
        last_rx = mo_bytes[byi];
        rx_total++;
      end
      repeat (h - 1) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_after();
    chk("rx_count", rx_wr, rx_total);
    while (rx_exp.size() > 0 && rx_rd < rx_wr) begin
      chk("rx_data", 32'(rx_mem[rx_rd[7:0]]), 32'(rx_exp.pop_front()));
      rx_rd++;
    end
    rx_exp.delete();
    rx_rd = rx_wr;
    chk("rx_hold", 32'(rx_data), 32'(last_rx));
    chk("tx_ready_cnt", n_ready, ready_exp);
    chk("busy_idle", 32'(busy), 32'(1'b0));
    chk("miso_idle", 32'(miso), 32'(MISO_IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'(MISO_IDLE));
    chk("rst_tx_ready", 32'(tx_ready), 32'(1'b0));
    chk("rst_rx_data", 32'(rx_data), 32'(8'h00));
    chk("rst_rx_valid", 32'(rx_valid), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte at 4:1
    push_tx(8'h3C);
    mo_bytes[0] = 8'hA5;
    frame(8, 2);
    check_after();

    // Two back-to-back bytes in one select
    push_tx(8'hAB);
    push_tx(8'hCD);
    mo_bytes[0] = 8'h12;
    mo_bytes[1] = 8'h34;
    frame(16, 3);
    check_after();

    // No TX data offered
    mo_bytes[0] = 8'hFF;
    frame(8, 2);
    check_after();

    // Abort after 5 bits, then a clean byte
    mo_bytes[0] = 8'h5A;
    frame(5, 3);
    mo_bytes[0] = 8'h81;
    frame(8, 3);
    check_after();

    // Reset in the middle of a byte
    mo_bytes[0] = 8'hFF;
    ss_n = 1'b0;
    mosi = 1'b1;
    ready_exp++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sck = 1'b1;
      repeat (3) @(negedge clk);
      sck = 1'b0;
      repeat (3) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", 32'(miso), 32'(MISO_IDLE));
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'(1'b0));
    chk("mid_rst_rx_data", 32'(rx_data), 32'(8'h00));
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'(1'b0));
    chk("mid_rst_busy", 32'(busy), 32'(1'b0));
    last_rx = 8'h00;
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push_tx(8'h96);
    mo_bytes[0] = 8'h3E;
    frame(8, 2);
    check_after();

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      int nb, h, ntx;
      nb  = $urandom_range(1, 3);
      h   = $urandom_range(2, 5);
      ntx = $urandom_range(0, nb);
      for (int i = 0; i < ntx; i++) push_tx(8'($urandom));
      for (int i = 0; i < nb; i++) mo_bytes[i] = 8'($urandom);
      frame(nb * 8, h);
      check_after();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
